trap_controller: RTL and testbench

TRAP_CONTROLLER -- requirements
Module: trap_controller

---
 rtl/trap_controller_if.sv | 38 +++
 rtl/trap_controller.sv | 124 ++++++++++++
 tb/tb_trap_controller.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/trap_controller_if.sv
// Signal bundle between the pipeline and the trap controller. It carries the trap and MRET requests,
// the instruction CSR write request, the CSR-file write port and the fetch redirect.
interface trap_controller_if;
    logic        i_TrapValid;
    logic        i_TrapIsInterrupt;
    logic [4:0]  i_TrapCause;
    logic [31:0] i_TrapPc;
    logic [31:0] i_TrapTval;
    logic        i_MretValid;
    logic [31:0] i_Mtvec;
    logic [31:0] i_Mepc;
    logic        i_InstrCsrReq;
    logic [11:0] i_InstrCsrNumber;
    logic [31:0] i_InstrCsrData;
    logic        o_InstrCsrGrant;
    logic        o_CsrWriteEnable;
    logic [11:0] o_CsrNumber;
    logic [31:0] o_CsrWriteData;
    logic        o_Stall;
    logic        o_RedirectValid;
    logic [31:0] o_RedirectPc;

    modport slave (
        input  i_TrapValid, i_TrapIsInterrupt, i_TrapCause, i_TrapPc, i_TrapTval,
        input  i_MretValid, i_Mtvec, i_Mepc,
        input  i_InstrCsrReq, i_InstrCsrNumber, i_InstrCsrData,
        output o_InstrCsrGrant, o_CsrWriteEnable, o_CsrNumber, o_CsrWriteData,
        output o_Stall, o_RedirectValid, o_RedirectPc
    );

    modport master (
        output i_TrapValid, i_TrapIsInterrupt, i_TrapCause, i_TrapPc, i_TrapTval,
        output i_MretValid, i_Mtvec, i_Mepc,
        output i_InstrCsrReq, i_InstrCsrNumber, i_InstrCsrData,
        input  o_InstrCsrGrant, o_CsrWriteEnable, o_CsrNumber, o_CsrWriteData,
        input  o_Stall, o_RedirectValid, o_RedirectPc
    );
endinterface

// File: rtl/trap_controller.sv
// Machine-mode trap/MRET sequencer. It serialises the mepc/mcause/mtval writes onto the single CSR
// write port, computes the fetch redirect, and lets instruction CSR writes through while idle.
module trap_controller #(
    parameter int MTVAL_ENABLE = 1
) (
    input  logic              i_Clock,
    input  logic              i_Reset_n,
    trap_controller_if.slave  bus
);
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        W_EPC    = 3'd1,
        W_CAUSE  = 3'd2,
        W_TVAL   = 3'd3,
        REDIRECT = 3'd4
    } state_t;

    state_t      state, state_next;
    logic [29:0] cap_pc;
    logic [31:0] cap_tval;
    logic [4:0]  cap_cause;
    logic        cap_irq;
    logic [31:0] cap_mtvec;
    logic [29:0] cap_epc;
    logic        cap_is_mret;
    logic [31:0] vec_base;
    logic [31:0] trap_target;

    // Only vectored mode with an interrupt offsets the base; reserved modes fall back to direct.
    assign vec_base    = {cap_mtvec[31:2], 2'b00};
    assign trap_target = (cap_mtvec[1:0] == 2'b01 && cap_irq)
                         ? vec_base + {25'd0, cap_cause, 2'b00} : vec_base;

    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            state       <= IDLE;
            cap_pc      <= '0;
            cap_tval    <= '0;
            cap_cause   <= '0;
            cap_irq     <= 1'b0;
            cap_mtvec   <= '0;
            cap_epc     <= '0;
            cap_is_mret <= 1'b0;
        end else begin
            state <= state_next;
            if (state == IDLE && bus.i_TrapValid) begin
                cap_pc      <= bus.i_TrapPc[31:2];
                cap_tval    <= bus.i_TrapTval;
                cap_cause   <= bus.i_TrapCause;
                cap_irq     <= bus.i_TrapIsInterrupt;
                cap_mtvec   <= bus.i_Mtvec;
                cap_is_mret <= 1'b0;
            end else if (state == IDLE && bus.i_MretValid) begin
                cap_epc     <= bus.i_Mepc[31:2];
                cap_is_mret <= 1'b1;
            end
        end
    end

    always_comb begin
        state_next           = state;
        bus.o_InstrCsrGrant  = 1'b0;
        bus.o_CsrWriteEnable = 1'b0;
        bus.o_CsrNumber      = '0;
        bus.o_CsrWriteData   = '0;
        bus.o_Stall          = 1'b0;
        bus.o_RedirectValid  = 1'b0;
        bus.o_RedirectPc     = '0;
        case (state)
            IDLE: begin
                if (bus.i_TrapValid) begin
                    state_next  = W_EPC;
                    bus.o_Stall = 1'b1;
                end else if (bus.i_MretValid) begin
                    state_next  = REDIRECT;
                    bus.o_Stall = 1'b1;
                end else if (bus.i_InstrCsrReq) begin
                    bus.o_InstrCsrGrant  = 1'b1;
                    bus.o_CsrWriteEnable = 1'b1;
                    bus.o_CsrNumber      = bus.i_InstrCsrNumber;
                    bus.o_CsrWriteData   = bus.i_InstrCsrData;
                end
            end
            W_EPC: begin
                state_next           = W_CAUSE;
                bus.o_Stall          = 1'b1;
                bus.o_CsrWriteEnable = 1'b1;
                bus.o_CsrNumber      = 12'h341;
                bus.o_CsrWriteData   = {cap_pc, 2'b00};
            end
            W_CAUSE: begin
                state_next           = (MTVAL_ENABLE != 0) ? W_TVAL : REDIRECT;
                bus.o_Stall          = 1'b1;
                bus.o_CsrWriteEnable = 1'b1;
                bus.o_CsrNumber      = 12'h342;
                bus.o_CsrWriteData   = {cap_irq, 26'd0, cap_cause};
            end
            W_TVAL: begin
                state_next           = REDIRECT;
                bus.o_Stall          = 1'b1;
                bus.o_CsrWriteEnable = 1'b1;
                bus.o_CsrNumber      = 12'h343;
                bus.o_CsrWriteData   = cap_tval;
            end
            REDIRECT: begin
                state_next          = IDLE;
                bus.o_Stall         = 1'b1;
                bus.o_RedirectValid = 1'b1;
                bus.o_RedirectPc    = cap_is_mret ? {cap_epc, 2'b00} : trap_target;
            end
            default: state_next = IDLE;
        endcase
        // The grant path is combinational, so reset must also mask it.
        if (!i_Reset_n) begin
            bus.o_InstrCsrGrant  = 1'b0;
            bus.o_CsrWriteEnable = 1'b0;
            bus.o_CsrNumber      = '0;
            bus.o_CsrWriteData   = '0;
            bus.o_Stall          = 1'b0;
            bus.o_RedirectValid  = 1'b0;
            bus.o_RedirectPc     = '0;
        end
    end
endmodule

// File: tb/tb_trap_controller.sv
// Directed bench for trap_controller: one instance with mtval writes enabled, one without.
module tb_trap_controller;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   failed = 0;

    always #5 clk = ~clk;

    trap_controller_if bus1 ();
    trap_controller_if bus0 ();

    trap_controller #(.MTVAL_ENABLE(1)) u_dut1 (.i_Clock(clk), .i_Reset_n(rst_n), .bus(bus1));
    trap_controller #(.MTVAL_ENABLE(0)) u_dut0 (.i_Clock(clk), .i_Reset_n(rst_n), .bus(bus0));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic exp1(input string tag, input logic we, input logic [11:0] num, input logic [31:0] data,
                        input logic stall, input logic rv, input logic [31:0] rpc, input logic grant);
        chk({tag, ".we"},    {31'd0, bus1.o_CsrWriteEnable}, {31'd0, we});
        chk({tag, ".num"},   {20'd0, bus1.o_CsrNumber},      {20'd0, num});
        chk({tag, ".data"},  bus1.o_CsrWriteData,            data);
        chk({tag, ".stall"}, {31'd0, bus1.o_Stall},          {31'd0, stall});
        chk({tag, ".rv"},    {31'd0, bus1.o_RedirectValid},  {31'd0, rv});
        chk({tag, ".rpc"},   bus1.o_RedirectPc,              rpc);
        chk({tag, ".grant"}, {31'd0, bus1.o_InstrCsrGrant},  {31'd0, grant});
    endtask

    task automatic exp0(input string tag, input logic we, input logic [11:0] num, input logic [31:0] data,
                        input logic stall, input logic rv, input logic [31:0] rpc);
        chk({tag, ".we"},    {31'd0, bus0.o_CsrWriteEnable}, {31'd0, we});
        chk({tag, ".num"},   {20'd0, bus0.o_CsrNumber},      {20'd0, num});
        chk({tag, ".data"},  bus0.o_CsrWriteData,            data);
        chk({tag, ".stall"}, {31'd0, bus0.o_Stall},          {31'd0, stall});
        chk({tag, ".rv"},    {31'd0, bus0.o_RedirectValid},  {31'd0, rv});
        chk({tag, ".rpc"},   bus0.o_RedirectPc,              rpc);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic trap1(input logic irq, input logic [4:0] cause, input logic [31:0] pc,
                         input logic [31:0] tval, input logic [31:0] mtvec);
        bus1.i_TrapValid       = 1'b1;
        bus1.i_TrapIsInterrupt = irq;
        bus1.i_TrapCause       = cause;
        bus1.i_TrapPc          = pc;
        bus1.i_TrapTval        = tval;
        bus1.i_Mtvec           = mtvec;
    endtask

    initial begin
        {bus1.i_TrapValid, bus1.i_TrapIsInterrupt, bus1.i_TrapCause, bus1.i_TrapPc, bus1.i_TrapTval} = '0;
        {bus1.i_MretValid, bus1.i_Mtvec, bus1.i_Mepc} = '0;
        {bus1.i_InstrCsrReq, bus1.i_InstrCsrNumber, bus1.i_InstrCsrData} = '0;
        {bus0.i_TrapValid, bus0.i_TrapIsInterrupt, bus0.i_TrapCause, bus0.i_TrapPc, bus0.i_TrapTval} = '0;
        {bus0.i_MretValid, bus0.i_Mtvec, bus0.i_Mepc} = '0;
        {bus0.i_InstrCsrReq, bus0.i_InstrCsrNumber, bus0.i_InstrCsrData} = '0;

        // Reset: outputs 0 even with a CSR request pending
        bus1.i_InstrCsrReq = 1'b1;
        bus1.i_InstrCsrNumber = 12'h300;
        bus1.i_InstrCsrData = 32'h55;
        tick();
        tick();
        exp1("rst", 0, 12'h0, 32'h0, 0, 0, 32'h0, 0);
        exp0("rst0", 0, 12'h0, 32'h0, 0, 0, 32'h0);
        rst_n = 1'b1;
        #1;
        exp1("csr_alone", 1, 12'h300, 32'h55, 0, 0, 32'h0, 1);
        bus1.i_InstrCsrReq = 1'b0;

        // Direct exception, trap held through the sequence to check it is ignored
        tick();
        trap1(1'b0, 5'd2, 32'h1004, 32'hDEAD, 32'h8000_0100);
        #1;
        exp1("exc.T", 0, 12'h0, 32'h0, 1, 0, 32'h0, 0);
        tick(); exp1("exc.T1", 1, 12'h341, 32'h1004, 1, 0, 32'h0, 0);
        tick(); exp1("exc.T2", 1, 12'h342, 32'h2, 1, 0, 32'h0, 0);
        tick(); exp1("exc.T3", 1, 12'h343, 32'hDEAD, 1, 0, 32'h0, 0);
        tick(); bus1.i_TrapValid = 1'b0; #1;
        exp1("exc.T4", 0, 12'h0, 32'h0, 1, 1, 32'h8000_0100, 0);
        tick(); exp1("exc.T5", 0, 12'h0, 32'h0, 0, 0, 32'h0, 0);

        // Vectored interrupt with an unaligned pc
        trap1(1'b1, 5'd7, 32'h3003, 32'h0, 32'h8000_0101);
        #1;
        exp1("vec.T", 0, 12'h0, 32'h0, 1, 0, 32'h0, 0);
        tick(); bus1.i_TrapValid = 1'b0; #1;
        exp1("vec.T1", 1, 12'h341, 32'h3000, 1, 0, 32'h0, 0);
        tick(); exp1("vec.T2", 1, 12'h342, 32'h8000_0007, 1, 0, 32'h0, 0);
        tick(); exp1("vec.T3", 1, 12'h343, 32'h0, 1, 0, 32'h0, 0);
        tick(); exp1("vec.T4", 0, 12'h0, 32'h0, 1, 1, 32'h8000_011C, 0);
        tick();

        // Reserved mode 3 with an interrupt: no vector offset
        trap1(1'b1, 5'd3, 32'h4000, 32'h77, 32'h8000_0103);
        tick(); bus1.i_TrapValid = 1'b0;
        tick(); tick(); tick();
        exp1("rsv.T4", 0, 12'h0, 32'h0, 1, 1, 32'h8000_0100, 0);
        tick();

        // Vectored mode with an exception: base only
        trap1(1'b0, 5'd5, 32'h4000, 32'h0, 32'h9000_0001);
        tick(); bus1.i_TrapValid = 1'b0;
        tick(); tick(); tick();
        exp1("vexc.T4", 0, 12'h0, 32'h0, 1, 1, 32'h9000_0000, 0);
        tick();

        // MRET
        bus1.i_MretValid = 1'b1;
        bus1.i_Mepc = 32'h2002;
        #1;
        exp1("mret.T", 0, 12'h0, 32'h0, 1, 0, 32'h0, 0);
        tick(); bus1.i_MretValid = 1'b0; #1;
        exp1("mret.T1", 0, 12'h0, 32'h0, 1, 1, 32'h2000, 0);
        tick(); exp1("mret.T2", 0, 12'h0, 32'h0, 0, 0, 32'h0, 0);

        // Trap, MRET and CSR request together; CSR request held until granted
        trap1(1'b0, 5'd2, 32'h1004, 32'hDEAD, 32'h8000_0100);
        bus1.i_MretValid = 1'b1;
        bus1.i_Mepc = 32'h2002;
        bus1.i_InstrCsrReq = 1'b1;
        bus1.i_InstrCsrNumber = 12'h305;
        bus1.i_InstrCsrData = 32'hABCD_0000;
        #1;
        exp1("arb.T", 0, 12'h0, 32'h0, 1, 0, 32'h0, 0);
        tick(); bus1.i_TrapValid = 1'b0; bus1.i_MretValid = 1'b0; #1;
        exp1("arb.T1", 1, 12'h341, 32'h1004, 1, 0, 32'h0, 0);
        tick(); exp1("arb.T2", 1, 12'h342, 32'h2, 1, 0, 32'h0, 0);
        tick(); exp1("arb.T3", 1, 12'h343, 32'hDEAD, 1, 0, 32'h0, 0);
        tick(); exp1("arb.T4", 0, 12'h0, 32'h0, 1, 1, 32'h8000_0100, 0);
        tick(); exp1("arb.T5", 1, 12'h305, 32'hABCD_0000, 0, 0, 32'h0, 1);
        bus1.i_InstrCsrReq = 1'b0;
        tick(); exp1("arb.T6", 0, 12'h0, 32'h0, 0, 0, 32'h0, 0);

        // MTVAL_ENABLE=0 instance
        bus0.i_TrapValid = 1'b1;
        bus0.i_TrapCause = 5'd2;
        bus0.i_TrapPc = 32'h1004;
        bus0.i_TrapTval = 32'hDEAD;
        bus0.i_Mtvec = 32'h8000_0100;
        #1;
        exp0("nt.T", 0, 12'h0, 32'h0, 1, 0, 32'h0);
        tick(); bus0.i_TrapValid = 1'b0; #1;
        exp0("nt.T1", 1, 12'h341, 32'h1004, 1, 0, 32'h0);
        tick(); exp0("nt.T2", 1, 12'h342, 32'h2, 1, 0, 32'h0);
        tick(); exp0("nt.T3", 0, 12'h0, 32'h0, 1, 1, 32'h8000_0100);
        tick(); exp0("nt.T4", 0, 12'h0, 32'h0, 0, 0, 32'h0);

        // Reset asserted during W_CAUSE abandons the sequence
        trap1(1'b0, 5'd2, 32'h1004, 32'hDEAD, 32'h8000_0100);
        tick(); bus1.i_TrapValid = 1'b0;
        tick();
        exp1("rstmid.W_CAUSE", 1, 12'h342, 32'h2, 1, 0, 32'h0, 0);
        rst_n = 1'b0;
        #1;
        exp1("rstmid.async", 0, 12'h0, 32'h0, 0, 0, 32'h0, 0);
        tick(); tick();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            exp1($sformatf("rstmid.after%0d", i), 0, 12'h0, 32'h0, 0, 0, 32'h0, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
